reg_dump_streamer: RTL
======================

REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have start, input, 1, one-cycle request to begin a dump; sampled only in IDLE.
REQ-004 SHALL have abort, input, 1, synchronous cancel of a dump in progress.
REQ-005 SHALL have first_idx, input, 5, first register index to dump; latched on accepted start.
REQ-006 SHALL have last_idx, input, 5, last register index to dump, inclusive; latched on accepted start.
REQ-007 SHALL have rf_addr, output, 5, address driven to the register-file read port (A1/A2 side).
REQ-008 SHALL have rf_data, input, 32, combinational read data returned for rf_addr.
REQ-009 SHALL have out_valid, output, 1, out_data/out_index/out_last hold a beat.
REQ-010 SHALL have out_ready, input, 1, consumer accepts beat when out_valid && out_ready.
REQ-011 SHALL have out_data, output, 32, captured register value.
REQ-012 SHALL have out_index, output, 5, register index of out_data.
REQ-013 SHALL have out_last, output, 1, marks the final beat of the dump.
REQ-014 SHALL have busy, output, 1, high in RUN.
REQ-015 SHALL have done, output, 1, one-cycle pulse after the last beat is accepted.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE.
REQ-017 IDLE: start=1 and first_idx<=last_idx SHALL latch the range, load pointer=first_idx, and enter RUN next cycle.
REQ-018 IDLE: start=1 and first_idx>last_idx SHALL enter DONE directly, emitting no beats.
REQ-019 start SHALL be ignored outside IDLE.
REQ-020 rf_addr SHALL equal the pointer in RUN and 0 otherwise.
REQ-021 The output slot SHALL load when RUN, pointer not exhausted, and (!out_valid || out_ready), capturing rf_data, pointer, and last=(pointer==last_idx); the pointer then increments.
REQ-022 Throughput SHALL be one beat per cycle under continuous out_ready; first out_valid SHALL rise 2 cycles after the start cycle.
REQ-023 out_data/out_index/out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 The pointer SHALL be 6 bits wide or carry an exhausted flag so that last_idx=31 never wraps to 0 and re-reads.
REQ-025 Index 0 SHALL be streamed like any other; the value is whatever rf_data returns (0 by register-file rule).
REQ-026 Acceptance of the out_last beat SHALL move RUN->DONE; DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 abort=1 in RUN SHALL clear out_valid and return to IDLE next cycle without a done pulse; abort SHALL have no effect in IDLE or DONE.
REQ-028 abort and an out_last handshake in the same cycle SHALL resolve to abort (no done).

Reset
REQ-029 rst=1 SHALL force IDLE, pointer=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0, rf_addr=0 on the next edge, including mid-dump.
REQ-030 rst SHALL take priority over start and abort.

Structure
REQ-031 Shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the state encoding.
REQ-032 The output slot SHALL be a sub-module dump_out_stage (1-entry valid/ready register with load enable).
REQ-033 The block SHALL only read the register file; it SHALL NOT drive any write port.

Verification
REQ-034 Full dump: regs x1..x31 preloaded with 0x100+i, range 0..31, out_ready=1 -> 32 beats, index 0..31, data 0,0x101..0x11F, out_last only on index 31, done 1 cycle after it.
REQ-035 Backpressure: range 4..6, out_ready toggling 1010... -> beats 4,5,6 in order, outputs stable while stalled, no loss/duplication.
REQ-036 Single/empty: range 7..7 -> one beat, out_last=1; range 9..3 -> zero beats, done pulses 1 cycle after start.
REQ-037 Abort: range 0..31, abort at 5th beat -> out_valid low next cycle, no done, busy low, a new start is accepted.
REQ-038 Reset mid-dump: rst asserted at beat 10 -> all outputs 0 next edge; start ignored while rst=1.
REQ-039 start while busy: second start with range 2..3 during a dump 0..31 -> ignored; exactly 32 beats emitted.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// reg_dump_streamer_pkg: shared widths and FSM encoding for the register dump streamer
package reg_dump_streamer_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/dump_out_stage.sv
// dump_out_stage: one-entry valid/ready output register with load enable and flush
module dump_out_stage
    import reg_dump_streamer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [XLEN-1:0]       i_data,
    input  logic [REG_ADDR_W-1:0] i_index,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [XLEN-1:0]       o_data,
    output logic [REG_ADDR_W-1:0] o_index,
    output logic                  o_last
);
    logic                  r_valid;
    logic [XLEN-1:0]       r_data;
    logic [REG_ADDR_W-1:0] r_index;
    logic                  r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_index <= i_index;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_index = r_index;
    assign o_last  = r_last;
endmodule

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: walks a register-file index range and streams each value over valid/ready
module reg_dump_streamer
    import reg_dump_streamer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [REG_ADDR_W-1:0] first_idx,
    input  logic [REG_ADDR_W-1:0] last_idx,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]       rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [REG_ADDR_W-1:0] out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);
    logic [1:0]            r_state;
    logic [REG_ADDR_W:0]   r_ptr;
    logic [REG_ADDR_W-1:0] r_last_idx;
    logic                  w_run;
    logic                  w_exh;
    logic                  w_load;
    logic                  w_fire;

    // Extra pointer bit lets last_idx=31 run past the end without wrapping to 0
    assign w_run  = r_state == S_RUN;
    assign w_exh  = r_ptr > {1'b0, r_last_idx};
    assign w_fire = out_valid && out_ready;
    assign w_load = w_run && !abort && !w_exh && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_last_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_last_idx <= last_idx;
                    r_ptr      <= {1'b0, first_idx};
                    r_state    <= (first_idx <= last_idx) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (abort)
                        r_state <= S_IDLE;
                    else if (w_fire && out_last)
                        r_state <= S_DONE;
                    if (w_load)
                        r_ptr <= r_ptr + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    dump_out_stage u_out (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_run && abort),
        .i_load  (w_load),
        .i_data  (rf_data),
        .i_index (r_ptr[REG_ADDR_W-1:0]),
        .i_last  (r_ptr[REG_ADDR_W-1:0] == r_last_idx),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_index (out_index),
        .o_last  (out_last)
    );

    assign rf_addr = w_run ? r_ptr[REG_ADDR_W-1:0] : '0;
    assign busy    = w_run;
    assign done    = r_state == S_DONE;
endmodule
